pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-002 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-003 SHALL have port nRST  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports ihit, dhit  in  1 each  instruction/data memory hit.
REQ-005 SHALL have ports ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports idex_dest, exmem_dest  in  5 each  destination register of the ID/EX and EX/MEM instructions.
REQ-007 SHALL have ports idex_memread, idex_regwrite, exmem_regwrite  in  1 each  control bits of the ID/EX and EX/MEM instructions.
REQ-008 SHALL have ports exmem_memaccess, pc_redirect, halt_in  in  1 each  EX/MEM has dREN or dWEN; taken branch or jump resolved at EX/MEM; halt at MEM/WB.
REQ-009 SHALL have outputs pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen  out  1 each  register write enables.
REQ-010 SHALL have outputs ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load NOP, valid only when the matching wen=1.
REQ-011 SHALL have outputs halted  out  1, state  out  2 (ctrl_state_t), stall_cnt  out  CNT_W.

Function
REQ-012 SHALL implement states RUN, DWAIT, HALT, with registered state and Mealy outputs.
REQ-013 SHALL go to HALT from any state when halt_in=1, and SHALL leave HALT only on reset.
REQ-014 SHALL go RUN->DWAIT when exmem_memaccess=1 and dhit=0, and DWAIT->RUN on dhit=1; an access that hits in its first cycle SHALL not enter DWAIT.
REQ-015 SHALL, while dfreeze (exmem_memaccess and not dhit), drive all wen=0 and all flush=0, taking priority over every rule below.
REQ-016 SHALL, on redirect (pc_redirect=1, no dfreeze), drive all wen=1 and ifid_flush=idex_flush=exmem_flush=1, ignoring ihit and the load-use hazard.
REQ-017 SHALL detect load-use when idex_memread=1, idex_dest!=0 and idex_dest equals ifid_rs or ifid_rt.
REQ-018 SHALL, on load-use, drive pc_wen=ifid_wen=0, idex_wen=1, idex_flush=1, and exmem_wen=memwb_wen=1.
REQ-019 SHALL, on an imiss (ihit=0, no higher-priority rule), drive pc_wen=0, ifid_wen=1, ifid_flush=1, and leave the other stages advancing.
REQ-020 SHALL otherwise drive all wen=1 and all flush=0.
REQ-021 SHALL apply the priority order HALT > dfreeze > redirect > RAW stall > imiss.
REQ-022 SHALL drive halted=1 exactly when state=HALT, with all wen=0 and all flush=0 in HALT.
REQ-023 SHALL increment stall_cnt each cycle that state!=HALT and pc_wen=0, saturating at all-ones.

Reset
REQ-024 SHALL, while nRST=0 at a clock edge, load state=RUN and stall_cnt=0.
REQ-025 SHALL drive halted=0 and all wen/flush=0 while nRST=0.
REQ-026 SHALL, on a reset asserted mid-DWAIT or in HALT, return to RUN on the next edge, discarding the pending wait.

Configuration
REQ-027 SHALL treat forwarding as present when macro PIPE_FWD_EN is defined, in which case the only RAW stall is load-use (REQ-017).
REQ-028 SHALL, without PIPE_FWD_EN, also stall per REQ-018 when the ifid_rs/ifid_rt source is nonzero and either idex_regwrite=1 with idex_dest equal to that source, or exmem_regwrite=1 with exmem_dest equal to that source.

Structure
REQ-029 SHALL place ctrl_state_t (RUN=0, DWAIT=1, HALT=2) and regbits_t (5-bit) in cpu_types_pkg.
REQ-030 SHALL put the RAW comparison in a combinational sub-module hazard_detect, containing the PIPE_FWD_EN selection.

Verification
REQ-031 SHALL cover load-use: idex_memread=1, idex_dest=8, ifid_rt=8 -> pc_wen=0, ifid_wen=0, idex_flush=1, stall_cnt +1.
REQ-032 SHALL cover dcache miss: exmem_memaccess=1, dhit=0 for 3 cycles then 1 -> state DWAIT for 3 cycles, all wen=0, RUN after the hit.
REQ-033 SHALL cover redirect with imiss: pc_redirect=1, ihit=0 -> pc_wen=1, ifid_flush=idex_flush=exmem_flush=1.
REQ-034 SHALL cover halt during a dcache miss: halt_in=1 with a pending miss -> HALT next cycle, halted=1, all wen=0, held until nRST=0.
REQ-035 SHALL cover idex_dest=0 matching ifid_rs=0 -> no stall; and, without PIPE_FWD_EN, exmem_regwrite=1, exmem_dest=3, ifid_rs=3 -> stall.
REQ-036 SHALL cover saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: controller state encoding and register-index width.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

    typedef logic [4:0] regbits_t;

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard detection between the instruction in ID and the older in-flight instructions.
// Defining PIPE_FWD_EN assumes a forwarding network, so only load-use stalls remain.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    input  regbits_t idex_dest,
    input  regbits_t exmem_dest,
    input  logic     idex_memread,
    input  logic     idex_regwrite,
    input  logic     exmem_regwrite,
    output logic     raw_stall
);

    logic load_use;
    logic idex_dep;
    logic exmem_dep;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    assign load_use = idex_memread && (idex_dest != 5'd0) &&
                      ((idex_dest == ifid_rs) || (idex_dest == ifid_rt));

    assign idex_dep = idex_regwrite &&
                      (((ifid_rs != 5'd0) && (idex_dest == ifid_rs)) ||
                       ((ifid_rt != 5'd0) && (idex_dest == ifid_rt)));

    assign exmem_dep = exmem_regwrite &&
                       (((ifid_rs != 5'd0) && (exmem_dest == ifid_rs)) ||
                        ((ifid_rt != 5'd0) && (exmem_dest == ifid_rt)));

`ifdef PIPE_FWD_EN
    assign raw_stall = load_use;
    logic unused_dep;
    assign unused_dep = idex_dep ^ exmem_dep;
`else
    assign raw_stall = load_use || idex_dep || exmem_dep;
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush controller with data-cache wait and halt states.
// Optional forwarding configuration via macro PIPE_FWD_EN (see hazard_detect).
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic [4:0]       idex_dest,
    input  logic [4:0]       exmem_dest,
    input  logic             idex_memread,
    input  logic             idex_regwrite,
    input  logic             exmem_regwrite,
    input  logic             exmem_memaccess,
    input  logic             pc_redirect,
    input  logic             halt_in,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output ctrl_state_t      state,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_state_t next_state;
    logic        raw_stall;
    logic        dfreeze;

    assign dfreeze = exmem_memaccess && !dhit;

    hazard_detect u_hazard (
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .idex_dest      (idex_dest),
        .exmem_dest     (exmem_dest),
        .idex_memread   (idex_memread),
        .idex_regwrite  (idex_regwrite),
        .exmem_regwrite (exmem_regwrite),
        .raw_stall      (raw_stall)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) state <= RUN;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (halt_in) begin
            next_state = HALT;
        end else begin
            case (state)
                RUN:     if (dfreeze) next_state = DWAIT;
                DWAIT:   if (dhit)    next_state = RUN;
                HALT:    next_state = HALT;
                default: next_state = RUN;
            endcase
        end
    end

    // Mealy outputs; HALT and reset force every stage to hold.
    always_comb begin
        pc_wen      = 1'b0;
        ifid_wen    = 1'b0;
        idex_wen    = 1'b0;
        exmem_wen   = 1'b0;
        memwb_wen   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (nRST && (state != HALT) && !dfreeze) begin
            if (pc_redirect) begin
                {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen} = 5'b11111;
                {ifid_flush, idex_flush, exmem_flush} = 3'b111;
            end else if (raw_stall) begin
                {idex_wen, exmem_wen, memwb_wen} = 3'b111;
                idex_flush = 1'b1;
            end else if (!ihit) begin
                {ifid_wen, idex_wen, exmem_wen, memwb_wen} = 4'b1111;
                ifid_flush = 1'b1;
            end else begin
                {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen} = 5'b11111;
            end
        end
    end

    assign halted = nRST && (state == HALT);

    always_ff @(posedge CLK) begin
        if (!nRST)
            stall_cnt <= '0;
        else if ((state != HALT) && !pc_wen && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: table of single-cycle RUN vectors plus hand sequences
// for dcache wait, halt, reset recovery and counter saturation.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit;
    logic [4:0]  ifid_rs, ifid_rt, idex_dest, exmem_dest;
    logic        idex_memread, idex_regwrite, exmem_regwrite;
    logic        exmem_memaccess, pc_redirect, halt_in;
    logic        pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    logic        pc_wen_s, ifid_wen_s, idex_wen_s, exmem_wen_s, memwb_wen_s;
    logic        ifid_flush_s, idex_flush_s, exmem_flush_s, memwb_flush_s;
    logic        halted_s;
    logic [1:0]  state_s;
    logic [3:0]  stall_cnt_s;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 CLK = ~CLK;

    pipeline_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_dest(idex_dest), .exmem_dest(exmem_dest),
        .idex_memread(idex_memread), .idex_regwrite(idex_regwrite), .exmem_regwrite(exmem_regwrite),
        .exmem_memaccess(exmem_memaccess), .pc_redirect(pc_redirect), .halt_in(halt_in),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .idex_wen(idex_wen), .exmem_wen(exmem_wen),
        .memwb_wen(memwb_wen), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halted(halted),
        .state(state), .stall_cnt(stall_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) dut_small (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_dest(idex_dest), .exmem_dest(exmem_dest),
        .idex_memread(idex_memread), .idex_regwrite(idex_regwrite), .exmem_regwrite(exmem_regwrite),
        .exmem_memaccess(exmem_memaccess), .pc_redirect(pc_redirect), .halt_in(halt_in),
        .pc_wen(pc_wen_s), .ifid_wen(ifid_wen_s), .idex_wen(idex_wen_s), .exmem_wen(exmem_wen_s),
        .memwb_wen(memwb_wen_s), .ifid_flush(ifid_flush_s), .idex_flush(idex_flush_s),
        .exmem_flush(exmem_flush_s), .memwb_flush(memwb_flush_s), .halted(halted_s),
        .state(state_s), .stall_cnt(stall_cnt_s)
    );

    logic [4:0] wen_v;
    logic [3:0] flush_v;
    assign wen_v   = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen};
    assign flush_v = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

    typedef struct {
        logic       ihit;
        logic [4:0] rs, rt, idest, edest;
        logic       memread, idex_rw, exmem_rw, memaccess, dhit, redirect;
        logic [4:0] wen;
        logic [3:0] fl;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic ih, logic [4:0] rs, logic [4:0] rt, logic [4:0] idd,
                                logic [4:0] ed, logic mr, logic irw, logic erw, logic ma,
                                logic dh, logic rd, logic [4:0] w, logic [3:0] f);
        vec_t v;
        v.ihit = ih; v.rs = rs; v.rt = rt; v.idest = idd; v.edest = ed;
        v.memread = mr; v.idex_rw = irw; v.exmem_rw = erw; v.memaccess = ma;
        v.dhit = dh; v.redirect = rd; v.wen = w; v.fl = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b1;
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_dest = 5'd0; exmem_dest = 5'd0;
        idex_memread = 1'b0; idex_regwrite = 1'b0; exmem_regwrite = 1'b0;
        exmem_memaccess = 1'b0; pc_redirect = 1'b0; halt_in = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        ihit = v.ihit; dhit = v.dhit; ifid_rs = v.rs; ifid_rt = v.rt;
        idex_dest = v.idest; exmem_dest = v.edest; idex_memread = v.memread;
        idex_regwrite = v.idex_rw; exmem_regwrite = v.exmem_rw;
        exmem_memaccess = v.memaccess; pc_redirect = v.redirect; halt_in = 1'b0;
    endtask

    // Inputs are set just after a rising edge; outputs checked on the falling edge.
    task automatic step(input string name, input logic [4:0] w, input logic [3:0] f,
                        input logic [1:0] st_after);
        @(negedge CLK);
        check({name, ".wen"}, 32'(wen_v), 32'(w));
        check({name, ".flush"}, 32'(flush_v), 32'(f));
        if (!w[4] && exp_cnt < 65535) exp_cnt++;
        @(posedge CLK); #1;
        check({name, ".state"}, 32'(state), 32'(st_after));
        check({name, ".cnt"}, 32'(stall_cnt), 32'(exp_cnt));
    endtask

    initial begin
        vecs[0]  = mk(1, 5'd1, 5'd2, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 5'b11111, 4'b0000);
        vecs[1]  = mk(1, 5'd1, 5'd8, 5'd8, 5'd0, 1, 1, 0, 0, 1, 0, 5'b00111, 4'b0100);
        vecs[2]  = mk(1, 5'd9, 5'd2, 5'd9, 5'd0, 1, 1, 0, 0, 1, 0, 5'b00111, 4'b0100);
        vecs[3]  = mk(1, 5'd0, 5'd4, 5'd0, 5'd0, 1, 1, 0, 0, 1, 0, 5'b11111, 4'b0000);
        vecs[4]  = mk(0, 5'd1, 5'd2, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 5'b01111, 4'b1000);
        vecs[5]  = mk(0, 5'd1, 5'd2, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 5'b11111, 4'b1110);
        vecs[6]  = mk(1, 5'd8, 5'd2, 5'd8, 5'd0, 1, 1, 0, 0, 1, 1, 5'b11111, 4'b1110);
        vecs[7]  = mk(0, 5'd8, 5'd2, 5'd8, 5'd0, 1, 1, 0, 0, 1, 0, 5'b00111, 4'b0100);
        vecs[8]  = mk(1, 5'd1, 5'd2, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 5'b11111, 4'b0000);
        vecs[9]  = mk(1, 5'd6, 5'd7, 5'd0, 5'd5, 0, 0, 1, 0, 1, 0, 5'b11111, 4'b0000);
        vecs[10] = mk(1, 5'd2, 5'd3, 5'd8, 5'd0, 1, 1, 0, 0, 1, 0, 5'b11111, 4'b0000);

        // Reset
        idle_inputs();
        nRST = 1'b0;
        @(negedge CLK);
        check("rst.wen", 32'(wen_v), 32'd0);
        check("rst.flush", 32'(flush_v), 32'd0);
        check("rst.halted", 32'(halted), 32'd0);
        @(posedge CLK); #1;
        check("rst.state", 32'(state), 32'd0);
        check("rst.cnt", 32'(stall_cnt), 32'd0);
        nRST = 1'b1;
        exp_cnt = 0;

        for (int i = 0; i < 11; i++) begin
            drive_vec(vecs[i]);
            step($sformatf("vec%0d", i), vecs[i].wen, vecs[i].fl, 2'd0);
        end

        // Non-load dependencies: stall only without forwarding
        idle_inputs();
        exmem_regwrite = 1'b1; exmem_dest = 5'd3; ifid_rs = 5'd3;
`ifdef PIPE_FWD_EN
        step("exmem_dep", 5'b11111, 4'b0000, 2'd0);
`else
        step("exmem_dep", 5'b00111, 4'b0100, 2'd0);
`endif
        idle_inputs();
        idex_regwrite = 1'b1; idex_dest = 5'd4; ifid_rt = 5'd4;
`ifdef PIPE_FWD_EN
        step("idex_dep", 5'b11111, 4'b0000, 2'd0);
`else
        step("idex_dep", 5'b00111, 4'b0100, 2'd0);
`endif

        // Dcache miss for 3 cycles (with redirect pending), then hit
        idle_inputs();
        exmem_memaccess = 1'b1; dhit = 1'b0; pc_redirect = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("dmiss%0d", i), 5'b00000, 4'b0000, 2'd1);
        dhit = 1'b1;
        step("dmiss_hit", 5'b11111, 4'b1110, 2'd0);

        // Reset in the middle of a dcache wait
        idle_inputs();
        exmem_memaccess = 1'b1; dhit = 1'b0;
        step("dwait_enter", 5'b00000, 4'b0000, 2'd1);
        nRST = 1'b0;
        @(negedge CLK);
        check("dwait_rst.wen", 32'(wen_v), 32'd0);
        @(posedge CLK); #1;
        check("dwait_rst.state", 32'(state), 32'd0);
        check("dwait_rst.cnt", 32'(stall_cnt), 32'd0);
        nRST = 1'b1;
        exp_cnt = 0;

        // Halt during a dcache miss, then held until reset
        step("halt_miss0", 5'b00000, 4'b0000, 2'd1);
        halt_in = 1'b1;
        step("halt_miss1", 5'b00000, 4'b0000, 2'd2);
        check("halt.halted", 32'(halted), 32'd1);
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("halt_hold.wen", 32'(wen_v), 32'd0);
            check("halt_hold.flush", 32'(flush_v), 32'd0);
            check("halt_hold.halted", 32'(halted), 32'd1);
            @(posedge CLK); #1;
            check("halt_hold.state", 32'(state), 32'd2);
            check("halt_hold.cnt", 32'(stall_cnt), 32'(exp_cnt));
        end
        nRST = 1'b0;
        @(negedge CLK);
        check("halt_rst.halted", 32'(halted), 32'd0);
        check("halt_rst.wen", 32'(wen_v), 32'd0);
        @(posedge CLK); #1;
        check("halt_rst.state", 32'(state), 32'd0);
        check("halt_rst.cnt", 32'(stall_cnt), 32'd0);
        nRST = 1'b1;
        exp_cnt = 0;
        step("post_halt", 5'b11111, 4'b0000, 2'd0);

        // 20 load-use stall cycles: 16-bit counter reaches 20, 4-bit saturates at 15
        idex_memread = 1'b1; idex_dest = 5'd8; ifid_rt = 5'd8;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
        end
        check("sat.cnt16", 32'(stall_cnt), 32'd20);
        check("sat.cnt4", 32'(stall_cnt_s), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
